obstacle_gen: RTL and testbench
===============================

OBSTACLE_GEN -- requirements
Module: obstacle_gen

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1: LFSR reload value; 16'h0000 is replaced by 16'h0001.
REQ-002 SHALL have parameter MIN_GAP, default 6: minimum empty columns between obstacles; legal range 1..31.
REQ-003 SHALL have parameter MAX_GAP, default 15: maximum empty columns; legal range MIN_GAP..31.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  level; while high, clears and reseeds the generator, same as reset except for priority.
REQ-007 SHALL have port req  input  1  one-cycle request for the next column from the downstream scroll register.
REQ-008 SHALL have port col  output  2  height of the emitted column: 0 = empty floor, 1..3 = obstacle height.
REQ-009 SHALL have port col_valid  output  1  one-cycle pulse marking col as updated.
REQ-010 SHALL have port obst_count  output  8  number of obstacles emitted since reset/start; saturates at 255.

Function
REQ-011 SHALL accept a request when req=1 and start=0; req is ignored while start=1.
REQ-012 SHALL drive col_valid=1 exactly one cycle after each accepted request, and 0 otherwise.
REQ-013 SHALL hold col stable between accepted requests.
REQ-014 SHALL accept back-to-back requests every cycle, producing one column per request with no drops.
REQ-015 SHALL implement a 16-bit Fibonacci LFSR using polynomial x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
REQ-016 SHALL advance the LFSR exactly once per emitted obstacle, on the S_OBST request, after the current value has been sampled.
REQ-017 SHALL implement states S_GAP, S_OBST and S_OBST2, plus a 5-bit gap_left counter.
REQ-018 In S_GAP, on an accepted request, SHALL emit col=0 and decrement gap_left; if gap_left was 1, SHALL move to S_OBST.
REQ-019 In S_OBST, on an accepted request, SHALL emit col=lfsr[1:0], or col=1 when lfsr[1:0]=0.
REQ-020 In S_OBST, SHALL load gap_left=min(MIN_GAP+lfsr[5:2], MAX_GAP).
REQ-021 In S_OBST, SHALL increment obst_count (saturating) and move to S_GAP, except as described in REQ-029.
REQ-022 In S_OBST2, on an accepted request, SHALL re-emit the previous obstacle height, move to S_GAP, and leave obst_count and gap_left unchanged.
REQ-023 SHALL not change state, LFSR or counters on cycles without an accepted request.
REQ-024 SHALL never emit two obstacle columns separated by fewer than MIN_GAP zero columns.
REQ-025 SHALL give start priority when start and req are high together: the request is dropped and col_valid stays 0 in the next cycle.

Reset
REQ-026 While resetn=0 or start=1, SHALL load state=S_GAP, gap_left=MIN_GAP and lfsr=SEED.
REQ-027 While resetn=0 or start=1, SHALL clear col, col_valid and obst_count to 0.
REQ-028 SHALL abort any in-progress gap or two-wide obstacle on mid-operation reset or start, with no residual col_valid pulse.

Configuration
REQ-029 Macro OBSTACLE_DOUBLE_EN defined: S_OBST SHALL go to S_OBST2 when lfsr[6]=1 (sampled before the shift), giving two-wide obstacles.
REQ-030 Macro OBSTACLE_DOUBLE_EN undefined: S_OBST2 SHALL not exist, and S_OBST SHALL always go to S_GAP.

Verification
REQ-031 Default parameters, start pulse, then 6 requests -> col=0 with col_valid pulses each time; 7th request -> col=1, obst_count=1.
REQ-032 Macro defined, continue from REQ-031 -> 8th request col=1, then 14 requests col=0, then 23rd request obstacle, obst_count=2.
REQ-033 Macro undefined, continue from REQ-031 -> requests 8..21 col=0; 22nd request obstacle, obst_count=2.
REQ-034 req held high for 40 cycles -> 40 col_valid pulses, each one cycle after its request; zero-run lengths always within 6..15.
REQ-035 start=1 and req=1 in the same cycle mid-gap -> next cycle col_valid=0, col=0, obst_count=0; sequence restarts as in REQ-031.
REQ-036 Force 300 obstacles via MIN_GAP=MAX_GAP=1 -> obst_count sticks at 255; resetn=0 for one cycle -> all outputs 0.

Source files
------------

// File: rtl/obstacle_gen_if.sv
// Column-request interface between a scroll register and the obstacle generator.
//   req        : one-cycle request for the next column (requester -> generator)
//   col        : height of the emitted column, 0 = empty floor, 1..3 = obstacle
//   col_valid  : one-cycle pulse marking col as updated
//   obst_count : obstacles emitted since reset/start, saturating at 255
// Modports: master = requester (scroll register), slave = generator.
interface obstacle_gen_if;
    logic       req;
    logic [1:0] col;
    logic       col_valid;
    logic [7:0] obst_count;

    modport master (output req, input col, input col_valid, input obst_count);
    modport slave  (input req, output col, output col_valid, output obst_count);
endinterface

// File: rtl/obstacle_gen.sv
// Pseudo-random obstacle column generator for a side-scrolling game.
// Emits one column per accepted request: runs of empty columns whose length
// is drawn from a 16-bit LFSR (bounded by MIN_GAP..MAX_GAP), separated by
// obstacles of height 1..3.
// Ports:
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   start  : level; while high clears and reseeds (req ignored meanwhile)
//   bus    : obstacle_gen_if.slave (req in; col, col_valid, obst_count out)
// Optional feature: define OBSTACLE_DOUBLE_EN to allow two-wide obstacles
// (S_OBST2 repeats the previous height when lfsr[6] was set).
module obstacle_gen #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned MIN_GAP = 6,
    parameter int unsigned MAX_GAP = 15
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    obstacle_gen_if.slave  bus
);

    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned GAP_W   = 5;
    localparam int unsigned SUM_W   = 6;
    localparam int unsigned COUNT_W = 8;

    // An all-zero LFSR would lock up, so a zero seed becomes 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

`ifdef OBSTACLE_DOUBLE_EN
    typedef enum logic [1:0] {S_GAP, S_OBST, S_OBST2} state_t;
`else
    typedef enum logic [1:0] {S_GAP, S_OBST} state_t;
`endif

    state_t               state_q, state_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [1:0]           col_q, col_d;
    logic                 valid_q, valid_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;

    logic                 lfsr_fb;
    logic [LFSR_W-1:0]    lfsr_next;
    logic [SUM_W-1:0]     gap_sum;
    logic [GAP_W-1:0]     gap_load;
    logic [1:0]           obst_height;

    // x^16+x^14+x^13+x^11+1, shifted left with feedback into bit 0
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_next = {lfsr_q[LFSR_W-2:0], lfsr_fb};

    // Next gap length, clamped to MAX_GAP
    assign gap_sum  = SUM_W'(MIN_GAP) + SUM_W'(lfsr_q[5:2]);
    assign gap_load = (gap_sum > SUM_W'(MAX_GAP)) ? GAP_W'(MAX_GAP) : gap_sum[GAP_W-1:0];

    // Height 0 would be indistinguishable from floor, so it maps to 1
    assign obst_height = (lfsr_q[1:0] == 2'd0) ? 2'd1 : lfsr_q[1:0];

    // State register and registered outputs; reset/start handled in next-state logic
    always_ff @(posedge clk) begin
        state_q <= state_d;
        gap_q   <= gap_d;
        lfsr_q  <= lfsr_d;
        col_q   <= col_d;
        valid_q <= valid_d;
        cnt_q   <= cnt_d;
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        lfsr_d  = lfsr_q;
        col_d   = col_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;

        if (!resetn || start) begin
            state_d = S_GAP;
            gap_d   = GAP_W'(MIN_GAP);
            lfsr_d  = SEED_EFF;
            col_d   = 2'd0;
            cnt_d   = '0;
        end else if (bus.req) begin
            valid_d = 1'b1;
            case (state_q)
                S_GAP: begin
                    col_d = 2'd0;
                    gap_d = gap_q - GAP_W'(1);
                    // <= guards against a corrupted zero count wrapping to 31
                    if (gap_q <= GAP_W'(1)) begin
                        state_d = S_OBST;
                    end
                end
                S_OBST: begin
                    col_d   = obst_height;
                    gap_d   = gap_load;
                    lfsr_d  = lfsr_next;
                    state_d = S_GAP;
                    if (cnt_q != {COUNT_W{1'b1}}) begin
                        cnt_d = cnt_q + COUNT_W'(1);
                    end
`ifdef OBSTACLE_DOUBLE_EN
                    if (lfsr_q[6]) begin
                        state_d = S_OBST2;
                    end
`endif
                end
`ifdef OBSTACLE_DOUBLE_EN
                // Second column of a two-wide obstacle repeats the held height
                S_OBST2: begin
                    state_d = S_GAP;
                end
`endif
                default: begin
                    state_d = S_GAP;
                end
            endcase
        end
    end

    assign bus.col        = col_q;
    assign bus.col_valid  = valid_q;
    assign bus.obst_count = cnt_q;

endmodule

// File: tb/tb_obstacle_gen.sv
// Directed self-checking bench for obstacle_gen: default-parameter instance
// for the sequence checks, and a MIN_GAP=MAX_GAP=1, zero-seed instance for
// saturation and seed-substitution checks.
module tb_obstacle_gen;

    logic clk;
    logic resetn;
    logic start;
    int   errors;
    int   checks;

    obstacle_gen_if bus ();
    obstacle_gen_if sat_bus ();

    obstacle_gen u_dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .bus    (bus)
    );

    obstacle_gen #(
        .SEED    (16'h0000),
        .MIN_GAP (1),
        .MAX_GAP (1)
    ) u_sat (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .bus    (sat_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One request on the main instance, followed by an idle cycle
    task automatic req_once(input string tag, input int exp_col, input int exp_cnt);
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        chk({tag, " valid"}, int'(bus.col_valid), 1);
        chk({tag, " col"}, int'(bus.col), exp_col);
        chk({tag, " cnt"}, int'(bus.obst_count), exp_cnt);
        tick();
        chk({tag, " idle"}, int'(bus.col_valid), 0);
        chk({tag, " hold"}, int'(bus.col), exp_col);
    endtask

    task automatic sat_req_once(input string tag, input int exp_col, input int exp_cnt);
        sat_bus.req = 1'b1;
        tick();
        sat_bus.req = 1'b0;
        chk({tag, " valid"}, int'(sat_bus.col_valid), 1);
        chk({tag, " col"}, int'(sat_bus.col), exp_col);
        chk({tag, " cnt"}, int'(sat_bus.obst_count), exp_cnt);
    endtask

    // Seed ACE1: 6 empty columns, then height 1 (lfsr[1:0]=01)
    task automatic first_obstacle(input string tag);
        for (int i = 1; i <= 6; i++) begin
            req_once($sformatf("%s gap%0d", tag, i), 0, 0);
        end
        req_once($sformatf("%s obst1", tag), 1, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int  zrun;
        int  pulses;
        bit  seen_obst;
        bit  ok;

        errors      = 0;
        checks      = 0;
        resetn      = 1'b0;
        start       = 1'b0;
        bus.req     = 1'b0;
        sat_bus.req = 1'b0;

        tick();
        tick();
        chk("rst col", int'(bus.col), 0);
        chk("rst valid", int'(bus.col_valid), 0);
        chk("rst cnt", int'(bus.obst_count), 0);

        resetn = 1'b1;
        tick();
        pulse_start();

        // Seed 0 becomes 1: heights 1 then 2, gap of one column each time
        sat_req_once("seed0 r1", 0, 0);
        sat_req_once("seed0 r2", 1, 1);
        sat_req_once("seed0 r3", 0, 1);
        sat_req_once("seed0 r4", 2, 2);

        // Main sequence: gap 6, height 1, gap 14, then height 3 (lfsr 59C3)
        first_obstacle("seq");
`ifdef OBSTACLE_DOUBLE_EN
        req_once("seq obst1b", 1, 1);
`endif
        for (int i = 1; i <= 14; i++) begin
            req_once($sformatf("seq gap2_%0d", i), 0, 1);
        end
        req_once("seq obst2", 3, 2);

        // start and req together after an obstacle and part of a gap
        pulse_start();
        first_obstacle("pre");
        req_once("pre gapA", 0, 1);
        req_once("pre gapB", 0, 1);
        start   = 1'b1;
        bus.req = 1'b1;
        tick();
        start   = 1'b0;
        bus.req = 1'b0;
        chk("startreq valid", int'(bus.col_valid), 0);
        chk("startreq col", int'(bus.col), 0);
        chk("startreq cnt", int'(bus.obst_count), 0);
        tick();
        chk("startreq idle", int'(bus.col_valid), 0);
        first_obstacle("restart");

        // Back-to-back requests for 40 cycles
        pulse_start();
        zrun      = 0;
        pulses    = 0;
        seen_obst = 1'b0;
        bus.req   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("b2b valid%0d", i), int'(bus.col_valid), 1);
            if (bus.col_valid) pulses++;
            if (bus.col == 2'd0) begin
                zrun++;
            end else begin
                if (seen_obst) begin
`ifdef OBSTACLE_DOUBLE_EN
                    ok = (zrun == 0) || (zrun >= 6 && zrun <= 15);
`else
                    ok = (zrun >= 6 && zrun <= 15);
`endif
                    chk($sformatf("b2b run%0d len%0d", i, zrun), int'(ok), 1);
                end else begin
                    chk("b2b first run", zrun, 6);
                end
                seen_obst = 1'b1;
                zrun      = 0;
            end
        end
        bus.req = 1'b0;
        tick();
        chk("b2b pulses", pulses, 40);
        chk("b2b end idle", int'(bus.col_valid), 0);
        chk("b2b cnt", int'(bus.obst_count), 4);

        // Saturation of obst_count on the gap-1 instance
        pulse_start();
        sat_bus.req = 1'b1;
        repeat (1000) tick();
        chk("sat cnt", int'(sat_bus.obst_count), 255);
        repeat (20) tick();
        chk("sat stick", int'(sat_bus.obst_count), 255);
        sat_bus.req = 1'b0;
        tick();

        // One-cycle reset clears everything
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rst2 sat cnt", int'(sat_bus.obst_count), 0);
        chk("rst2 sat col", int'(sat_bus.col), 0);
        chk("rst2 sat valid", int'(sat_bus.col_valid), 0);
        chk("rst2 col", int'(bus.col), 0);
        chk("rst2 valid", int'(bus.col_valid), 0);
        chk("rst2 cnt", int'(bus.obst_count), 0);
        tick();
        first_obstacle("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
